// File: rtl/pcie_egress_scheduler_pkg.sv
// rtl/pcie_egress_scheduler_pkg.sv - shared ids, FSM states and header field widths
// for the PCIe egress scheduler (optional build macro: PCIE_EGRESS_CPL_PRIORITY_EN).
package pcie_egress_scheduler_pkg;

  localparam logic [1:0] EGR_ID_CPL = 2'd0;
  localparam logic [1:0] EGR_ID_WR  = 2'd1;
  localparam logic [1:0] EGR_ID_RD  = 2'd2;

  localparam int EGR_CMD_W   = 8;
  localparam int EGR_FLAGS_W = 14;
  localparam int EGR_ADDR_W  = 64;
  localparam int EGR_RID_W   = 16;
  localparam int EGR_TAG_W   = 8;
  localparam int EGR_CNT_W   = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2
  } egr_state_t;

  typedef struct packed {
    logic [EGR_CMD_W-1:0]   command;
    logic [EGR_FLAGS_W-1:0] flags;
    logic [EGR_ADDR_W-1:0]  address;
    logic [EGR_RID_W-1:0]   requester_id;
    logic [EGR_TAG_W-1:0]   tag;
    logic [EGR_CNT_W-1:0]   dword_cnt;
  } egr_hdr_t;

  function automatic logic [1:0] egr_next_id(input logic [1:0] id);
    return (id == EGR_ID_RD) ? EGR_ID_CPL : id + 2'd1;
  endfunction

endpackage

// File: rtl/pcie_egress_rr_arbiter.sv
// rtl/pcie_egress_rr_arbiter.sv - 3-way round-robin pick with optional CPL priority
// override (PCIE_EGRESS_CPL_PRIORITY_EN).
module pcie_egress_rr_arbiter
  import pcie_egress_scheduler_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last_grant,
  output logic [2:0] gnt_onehot,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       ptr_update
);

  logic [2:0] rr_req;
  logic [1:0] c0, c1, c2;

  assign c0 = egr_next_id(last_grant);
  assign c1 = egr_next_id(c0);
  assign c2 = egr_next_id(c1);

  always_comb begin
    rr_req     = req;
    gnt_id     = EGR_ID_CPL;
    gnt_valid  = 1'b0;
    ptr_update = 1'b0;
`ifdef PCIE_EGRESS_CPL_PRIORITY_EN
    // CPL bypasses the rotation entirely and leaves the pointer alone.
    rr_req[EGR_ID_CPL] = 1'b0;
`endif
    if (rr_req[c0]) begin
      gnt_id     = c0;
      gnt_valid  = 1'b1;
      ptr_update = 1'b1;
    end else if (rr_req[c1]) begin
      gnt_id     = c1;
      gnt_valid  = 1'b1;
      ptr_update = 1'b1;
    end else if (rr_req[c2]) begin
      gnt_id     = c2;
      gnt_valid  = 1'b1;
      ptr_update = 1'b1;
    end
`ifdef PCIE_EGRESS_CPL_PRIORITY_EN
    if (req[EGR_ID_CPL]) begin
      gnt_id     = EGR_ID_CPL;
      gnt_valid  = 1'b1;
      ptr_update = 1'b0;
    end
`endif
    gnt_onehot = gnt_valid ? (3'b001 << gnt_id) : 3'b000;
  end

endmodule

// File: rtl/pcie_egress_scheduler.sv
// rtl/pcie_egress_scheduler.sv - shares the egress TLP engine between CPL/WR/RD requesters;
// optional build macro PCIE_EGRESS_CPL_PRIORITY_EN gives CPL strict priority.
module pcie_egress_scheduler
  import pcie_egress_scheduler_pkg::*;
#(
  parameter int WDOG_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cpl_req,
  input  logic        i_wr_req,
  input  logic        i_rd_req,
  input  logic [7:0]  i_cpl_command,
  input  logic [7:0]  i_wr_command,
  input  logic [7:0]  i_rd_command,
  input  logic [13:0] i_cpl_flags,
  input  logic [13:0] i_wr_flags,
  input  logic [13:0] i_rd_flags,
  input  logic [63:0] i_cpl_address,
  input  logic [63:0] i_wr_address,
  input  logic [63:0] i_rd_address,
  input  logic [15:0] i_cpl_requester_id,
  input  logic [15:0] i_wr_requester_id,
  input  logic [15:0] i_rd_requester_id,
  input  logic [7:0]  i_cpl_tag,
  input  logic [7:0]  i_wr_tag,
  input  logic [7:0]  i_rd_tag,
  input  logic [9:0]  i_cpl_dword_cnt,
  input  logic [9:0]  i_wr_dword_cnt,
  input  logic [9:0]  i_rd_dword_cnt,
  output logic        o_cpl_gnt,
  output logic        o_wr_gnt,
  output logic        o_rd_gnt,
  output logic        o_cpl_done,
  output logic        o_wr_done,
  output logic        o_rd_done,
  output logic        o_egress_enable,
  input  logic        i_egress_finished,
  output logic [7:0]  o_egress_command,
  output logic [13:0] o_egress_flags,
  output logic [63:0] o_egress_address,
  output logic [15:0] o_egress_requester_id,
  output logic [7:0]  o_egress_tag,
  output logic [9:0]  o_egress_req_dword_cnt,
  output logic [1:0]  o_egress_data_sel,
  output logic        o_busy,
  output logic        o_stall,
  output logic [1:0]  o_state
);

  egr_state_t        state_q, state_d;
  logic [1:0]        owner_q;
  logic [1:0]        last_grant_q;
  egr_hdr_t          hdr_q, hdr_sel;
  logic [2:0]        done_q;
  logic [WDOG_W-1:0] wdog_q;
  logic [2:0]        arb_onehot;
  logic [1:0]        arb_id;
  logic              arb_valid;
  logic              arb_ptr_update;
  logic [2:0]        gnt_vec;
  logic              grant_now;
  logic              wdog_sat;

  pcie_egress_rr_arbiter u_arb (
    .req        ({i_rd_req, i_wr_req, i_cpl_req}),
    .last_grant (last_grant_q),
    .gnt_onehot (arb_onehot),
    .gnt_id     (arb_id),
    .gnt_valid  (arb_valid),
    .ptr_update (arb_ptr_update)
  );

  always_comb begin
    hdr_sel = '0;
    case (arb_id)
      EGR_ID_CPL: hdr_sel = '{i_cpl_command, i_cpl_flags, i_cpl_address,
                              i_cpl_requester_id, i_cpl_tag, i_cpl_dword_cnt};
      EGR_ID_WR:  hdr_sel = '{i_wr_command, i_wr_flags, i_wr_address,
                              i_wr_requester_id, i_wr_tag, i_wr_dword_cnt};
      EGR_ID_RD:  hdr_sel = '{i_rd_command, i_rd_flags, i_rd_address,
                              i_rd_requester_id, i_rd_tag, i_rd_dword_cnt};
      default:    hdr_sel = '0;
    endcase
  end

  assign grant_now = (state_q == ST_IDLE) && arb_valid && (arb_onehot != 3'b000);
  assign wdog_sat  = (wdog_q == {WDOG_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (grant_now) state_d = ST_ISSUE;
      ST_ISSUE:   if (i_egress_finished) state_d = ST_RELEASE;
      // The engine keeps finished high for a cycle after enable drops.
      ST_RELEASE: if (!i_egress_finished) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q      <= EGR_ID_CPL;
      last_grant_q <= EGR_ID_RD;
      hdr_q        <= '0;
      done_q       <= 3'b000;
      wdog_q       <= '0;
    end else begin
      done_q <= 3'b000;
      if (grant_now) begin
        owner_q <= arb_id;
        hdr_q   <= hdr_sel;
        wdog_q  <= '0;
        if (arb_ptr_update) last_grant_q <= arb_id;
      end
      if (state_q == ST_ISSUE) begin
        if (!wdog_sat) wdog_q <= wdog_q + {{(WDOG_W-1){1'b0}}, 1'b1};
        if (i_egress_finished) done_q <= 3'b001 << owner_q;
      end
    end
  end

  always_comb begin
    o_busy          = (state_q != ST_IDLE);
    o_egress_enable = (state_q == ST_ISSUE);
    o_stall         = (state_q == ST_ISSUE) && wdog_sat;
    o_state         = state_q;
    gnt_vec         = o_busy ? (3'b001 << owner_q) : 3'b000;
    o_egress_data_sel = o_busy ? owner_q : EGR_ID_CPL;
  end

  assign o_cpl_gnt  = gnt_vec[EGR_ID_CPL];
  assign o_wr_gnt   = gnt_vec[EGR_ID_WR];
  assign o_rd_gnt   = gnt_vec[EGR_ID_RD];
  assign o_cpl_done = done_q[EGR_ID_CPL];
  assign o_wr_done  = done_q[EGR_ID_WR];
  assign o_rd_done  = done_q[EGR_ID_RD];

  assign o_egress_command       = hdr_q.command;
  assign o_egress_flags         = hdr_q.flags;
  assign o_egress_address       = hdr_q.address;
  assign o_egress_requester_id  = hdr_q.requester_id;
  assign o_egress_tag           = hdr_q.tag;
  assign o_egress_req_dword_cnt = hdr_q.dword_cnt;

endmodule

// File: tb/tb_pcie_egress_scheduler.sv
// tb/tb_pcie_egress_scheduler.sv - self-checking bench for pcie_egress_scheduler with an
// engine model and a round-robin reference model (honours PCIE_EGRESS_CPL_PRIORITY_EN).
module tb_pcie_egress_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [7:0]  cmd [3];
  logic [13:0] flg [3];
  logic [63:0] adr [3];
  logic [15:0] rid [3];
  logic [7:0]  tag [3];
  logic [9:0]  cnt [3];
  logic        finished = 1'b0;

  logic        o_cpl_gnt, o_wr_gnt, o_rd_gnt;
  logic        o_cpl_done, o_wr_done, o_rd_done;
  logic        o_egress_enable;
  logic [7:0]  o_egress_command;
  logic [13:0] o_egress_flags;
  logic [63:0] o_egress_address;
  logic [15:0] o_egress_requester_id;
  logic [7:0]  o_egress_tag;
  logic [9:0]  o_egress_req_dword_cnt;
  logic [1:0]  o_egress_data_sel;
  logic        o_busy, o_stall;
  logic [1:0]  o_state;

  int pass_cnt = 0;
  int total_cnt = 0;
  int model_ptr = 2;

  always #5 clk = ~clk;

  pcie_egress_scheduler #(.WDOG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cpl_req(req[0]), .i_wr_req(req[1]), .i_rd_req(req[2]),
    .i_cpl_command(cmd[0]), .i_wr_command(cmd[1]), .i_rd_command(cmd[2]),
    .i_cpl_flags(flg[0]), .i_wr_flags(flg[1]), .i_rd_flags(flg[2]),
    .i_cpl_address(adr[0]), .i_wr_address(adr[1]), .i_rd_address(adr[2]),
    .i_cpl_requester_id(rid[0]), .i_wr_requester_id(rid[1]), .i_rd_requester_id(rid[2]),
    .i_cpl_tag(tag[0]), .i_wr_tag(tag[1]), .i_rd_tag(tag[2]),
    .i_cpl_dword_cnt(cnt[0]), .i_wr_dword_cnt(cnt[1]), .i_rd_dword_cnt(cnt[2]),
    .o_cpl_gnt(o_cpl_gnt), .o_wr_gnt(o_wr_gnt), .o_rd_gnt(o_rd_gnt),
    .o_cpl_done(o_cpl_done), .o_wr_done(o_wr_done), .o_rd_done(o_rd_done),
    .o_egress_enable(o_egress_enable), .i_egress_finished(finished),
    .o_egress_command(o_egress_command), .o_egress_flags(o_egress_flags),
    .o_egress_address(o_egress_address), .o_egress_requester_id(o_egress_requester_id),
    .o_egress_tag(o_egress_tag), .o_egress_req_dword_cnt(o_egress_req_dword_cnt),
    .o_egress_data_sel(o_egress_data_sel), .o_busy(o_busy), .o_stall(o_stall),
    .o_state(o_state)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req = 3'b000;
    finished = 1'b0;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic rand_fields(input int i);
    cmd[i] = 8'($urandom);
    flg[i] = 14'($urandom);
    adr[i] = {$urandom, $urandom};
    rid[i] = 16'($urandom);
    tag[i] = 8'($urandom);
    cnt[i] = 10'($urandom);
  endtask

  // Engine model: finished rises after 'delay' enable cycles and is held one cycle
  // after enable falls. Returns what it observed; tests judge the results.
  task automatic run_engine(input int delay, input bit drop_req, output int gid,
                            output logic [2:0] gv, output int done_cnt,
                            output int rel_cycles, output bit en_in_rel, output bit timeout);
    int n;
    timeout = 1'b0; done_cnt = 0; rel_cycles = 0; en_in_rel = 1'b0; gid = -1; gv = 3'b000;
    n = 0;
    while (!o_egress_enable && n < 50) begin
      tick;
      n++;
    end
    if (!o_egress_enable) begin
      timeout = 1'b1;
      return;
    end
    gid = int'(o_egress_data_sel);
    gv = {o_rd_gnt, o_wr_gnt, o_cpl_gnt};
    if (drop_req) req = 3'b000;
    repeat (delay - 1) tick;
    finished = 1'b1;
    tick;
    n = 0;
    while (o_state == 2'd2 && n < 50) begin
      rel_cycles++;
      done_cnt += $countones({o_rd_done, o_wr_done, o_cpl_done});
      en_in_rel |= o_egress_enable;
      if (rel_cycles == 2) finished = 1'b0;
      tick;
      n++;
    end
    finished = 1'b0;
    done_cnt += $countones({o_rd_done, o_wr_done, o_cpl_done});
    if (n >= 50) timeout = 1'b1;
  endtask

  function automatic int model_pick(input logic [2:0] r);
    logic [2:0] rr;
    int c;
    rr = r;
`ifdef PCIE_EGRESS_CPL_PRIORITY_EN
    if (rr[0]) return 0;
    rr[0] = 1'b0;
`endif
    for (int k = 1; k <= 3; k++) begin
      c = (model_ptr + k) % 3;
      if (rr[c]) begin
        model_ptr = c;
        return c;
      end
    end
    return -1;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    total_cnt++; if (o_state !== 2'd0) $display("FAIL reset_state got %0d exp 0", o_state); else pass_cnt++;
    total_cnt++; if (o_egress_enable !== 1'b0) $display("FAIL reset_enable got %b exp 0", o_egress_enable); else pass_cnt++;
    total_cnt++; if ({o_rd_gnt, o_wr_gnt, o_cpl_gnt} !== 3'b000) $display("FAIL reset_gnt got %b exp 000", {o_rd_gnt, o_wr_gnt, o_cpl_gnt}); else pass_cnt++;
    total_cnt++; if ({o_busy, o_stall, o_egress_data_sel} !== 4'b0) $display("FAIL reset_misc got %b exp 0000", {o_busy, o_stall, o_egress_data_sel}); else pass_cnt++;
    total_cnt++; if (o_egress_address !== 64'd0) $display("FAIL reset_address got %h exp 0", o_egress_address); else pass_cnt++;
    do_reset;
  endtask

  task automatic test_single;
    int gid, dc, rc;
    logic [2:0] gv;
    bit er, to;
    do_reset;
    rand_fields(1);
    adr[1] = 64'h0000_0001_2000_0000;
    cnt[1] = 10'd4;
    req[1] = 1'b1;
    tick;
    total_cnt++; if (o_egress_enable !== 1'b1) $display("FAIL single_enable_latency got %b exp 1", o_egress_enable); else pass_cnt++;
    total_cnt++; if (o_wr_gnt !== 1'b1 || o_egress_data_sel !== 2'd1) $display("FAIL single_gnt got gnt=%b sel=%0d exp 1/1", o_wr_gnt, o_egress_data_sel); else pass_cnt++;
    total_cnt++; if (o_egress_address !== 64'h0000_0001_2000_0000) $display("FAIL single_address got %h exp 0000000120000000", o_egress_address); else pass_cnt++;
    total_cnt++; if (o_egress_req_dword_cnt !== 10'd4) $display("FAIL single_cnt got %0d exp 4", o_egress_req_dword_cnt); else pass_cnt++;
    run_engine(10, 1'b1, gid, gv, dc, rc, er, to);
    total_cnt++; if (to) $display("FAIL single_timeout got timeout exp none"); else pass_cnt++;
    total_cnt++; if (dc !== 1) $display("FAIL single_done_pulses got %0d exp 1", dc); else pass_cnt++;
    total_cnt++; if (o_state !== 2'd0 || o_wr_gnt !== 1'b0) $display("FAIL single_back_idle got state=%0d gnt=%b exp 0/0", o_state, o_wr_gnt); else pass_cnt++;
  endtask

  task automatic test_fairness;
    int gid, dc, rc;
    logic [2:0] gv;
    bit er, to;
    int exp_id;
    do_reset;
    for (int i = 0; i < 3; i++) rand_fields(i);
    req = 3'b111;
    for (int t = 0; t < 6; t++) begin
`ifdef PCIE_EGRESS_CPL_PRIORITY_EN
      exp_id = 0;
`else
      exp_id = t % 3;
`endif
      run_engine(2 + t, 1'b0, gid, gv, dc, rc, er, to);
      total_cnt++; if (to || gid !== exp_id) $display("FAIL fair_order_%0d got %0d exp %0d", t, gid, exp_id); else pass_cnt++;
      total_cnt++; if (gv !== (3'b001 << exp_id)) $display("FAIL fair_onehot_%0d got %b exp id %0d", t, gv, exp_id); else pass_cnt++;
      total_cnt++; if (rc < 2 || er) $display("FAIL fair_release_%0d got cycles=%0d en=%b exp >=2/0", t, rc, er); else pass_cnt++;
    end
    req = 3'b000;
    tick;
  endtask

  task automatic test_field_stability;
    do_reset;
    rand_fields(2);
    tag[2] = 8'h11;
    req[2] = 1'b1;
    tick;
    total_cnt++; if (o_rd_gnt !== 1'b1 || o_egress_tag !== 8'h11) $display("FAIL stab_grant got gnt=%b tag=%h exp 1/11", o_rd_gnt, o_egress_tag); else pass_cnt++;
    tag[2] = 8'h22;
    req = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tick;
      total_cnt++; if (o_egress_tag !== 8'h11) $display("FAIL stab_issue_%0d got %h exp 11", i, o_egress_tag); else pass_cnt++;
    end
    finished = 1'b1;
    tick;
    total_cnt++; if (o_state !== 2'd2 || o_egress_tag !== 8'h11 || o_rd_gnt !== 1'b1) $display("FAIL stab_release got state=%0d tag=%h gnt=%b exp 2/11/1", o_state, o_egress_tag, o_rd_gnt); else pass_cnt++;
    tick;
    finished = 1'b0;
    tick;
    total_cnt++; if (o_state !== 2'd0) $display("FAIL stab_idle got %0d exp 0", o_state); else pass_cnt++;
  endtask

  task automatic test_handshake;
    int gid, dc, rc;
    logic [2:0] gv;
    bit er, to;
    do_reset;
    finished = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      total_cnt++; if (o_state !== 2'd0 || o_egress_enable !== 1'b0 || o_wr_done !== 1'b0) $display("FAIL spurious_fin_%0d got state=%0d en=%b exp 0/0", i, o_state, o_egress_enable); else pass_cnt++;
    end
    finished = 1'b0;
    rand_fields(1);
    req[1] = 1'b1;
    run_engine(1, 1'b0, gid, gv, dc, rc, er, to);
    req = 3'b000;
    total_cnt++; if (to || gid !== 1) $display("FAIL hs_grant got %0d exp 1", gid); else pass_cnt++;
    total_cnt++; if (rc !== 2) $display("FAIL hs_release_cycles got %0d exp 2", rc); else pass_cnt++;
    total_cnt++; if (er) $display("FAIL hs_enable_in_release got 1 exp 0"); else pass_cnt++;
    total_cnt++; if (dc !== 1) $display("FAIL hs_done_pulses got %0d exp 1", dc); else pass_cnt++;
    tick;
  endtask

  task automatic test_watchdog;
    do_reset;
    rand_fields(1);
    req[1] = 1'b1;
    tick;
    req = 3'b000;
    total_cnt++; if (o_egress_enable !== 1'b1 || o_stall !== 1'b0) $display("FAIL wdog_start got en=%b stall=%b exp 1/0", o_egress_enable, o_stall); else pass_cnt++;
    repeat (14) tick;
    total_cnt++; if (o_stall !== 1'b0) $display("FAIL wdog_early got %b exp 0", o_stall); else pass_cnt++;
    tick;
    total_cnt++; if (o_stall !== 1'b1 || o_egress_enable !== 1'b1) $display("FAIL wdog_expired got stall=%b en=%b exp 1/1", o_stall, o_egress_enable); else pass_cnt++;
    repeat (5) tick;
    total_cnt++; if (o_stall !== 1'b1 || o_egress_enable !== 1'b1) $display("FAIL wdog_saturate got stall=%b en=%b exp 1/1", o_stall, o_egress_enable); else pass_cnt++;
    finished = 1'b1;
    tick;
    total_cnt++; if (o_stall !== 1'b0 || o_wr_done !== 1'b1) $display("FAIL wdog_clear got stall=%b done=%b exp 0/1", o_stall, o_wr_done); else pass_cnt++;
    tick;
    finished = 1'b0;
    tick;
  endtask

  task automatic test_async_reset;
    int gid, dc, rc;
    logic [2:0] gv;
    bit er, to;
    do_reset;
    rand_fields(1);
    req[1] = 1'b1;
    tick;
    req = 3'b000;
    tick;
    total_cnt++; if (o_egress_enable !== 1'b1) $display("FAIL arst_pre got %b exp 1", o_egress_enable); else pass_cnt++;
    #3 rst_n = 1'b0;
    #1;
    total_cnt++; if ({o_rd_gnt, o_wr_gnt, o_cpl_gnt, o_egress_enable} !== 4'b0) $display("FAIL arst_outputs got %b exp 0000", {o_rd_gnt, o_wr_gnt, o_cpl_gnt, o_egress_enable}); else pass_cnt++;
    total_cnt++; if ({o_rd_done, o_wr_done, o_cpl_done} !== 3'b0 || o_state !== 2'd0) $display("FAIL arst_state got done=%b state=%0d exp 0/0", {o_rd_done, o_wr_done, o_cpl_done}, o_state); else pass_cnt++;
    #10 rst_n = 1'b1;
    tick;
    for (int i = 0; i < 3; i++) rand_fields(i);
    req = 3'b111;
    run_engine(3, 1'b1, gid, gv, dc, rc, er, to);
    total_cnt++; if (to || gid !== 0) $display("FAIL arst_first_cpl got %0d exp 0", gid); else pass_cnt++;
  endtask

  task automatic test_random;
    int gid, dc, rc, exp_id;
    logic [2:0] gv, r;
    bit er, to;
    logic [137:0] exp_hdr, got_hdr;
    do_reset;
    model_ptr = 2;
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 3; i++) rand_fields(i);
      r = 3'($urandom_range(1, 7));
      exp_id = model_pick(r);
      exp_hdr = {cmd[exp_id], flg[exp_id], adr[exp_id], rid[exp_id], tag[exp_id], cnt[exp_id]};
      req = r;
      run_engine(int'($urandom_range(1, 5)), 1'b1, gid, gv, dc, rc, er, to);
      got_hdr = {o_egress_command, o_egress_flags, o_egress_address,
                 o_egress_requester_id, o_egress_tag, o_egress_req_dword_cnt};
      total_cnt++; if (to || gid !== exp_id || gv !== (3'b001 << exp_id)) $display("FAIL rand_grant_%0d req=%b got id=%0d gnt=%b exp %0d", t, r, gid, gv, exp_id); else pass_cnt++;
      total_cnt++; if (got_hdr !== exp_hdr) $display("FAIL rand_header_%0d got %h exp %h", t, got_hdr, exp_hdr); else pass_cnt++;
      total_cnt++; if (dc !== 1 || rc < 2) $display("FAIL rand_done_%0d got pulses=%0d rel=%0d exp 1/>=2", t, dc, rc); else pass_cnt++;
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      cmd[i] = '0; flg[i] = '0; adr[i] = '0; rid[i] = '0; tag[i] = '0; cnt[i] = '0;
    end
    test_reset;
    test_single;
    test_fairness;
    test_field_stability;
    test_handshake;
    test_watchdog;
    test_async_reset;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pcie_egress_scheduler.md
Name: pcie_egress_scheduler

Overview:
- Shares the single PCIe egress TLP engine between three requesters: completion (CPL, id 0), memory write (WR, id 1) and memory read request (RD, id 2).
- Arbitrates among the three, latches the winner's header fields and drives the engine's enable/finished handshake.
- Reports completion to the winner and steers the engine's FIFO data mux.
- Sits between the host-interface command decoders and the egress engine.

Parameters:
- WDOG_W, 16, width of the stall watchdog counter; stall flagged at 2^WDOG_W-1 cycles.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_cpl_req / i_wr_req / i_rd_req  in  1 each  level request
- i_cpl_command / i_wr_command / i_rd_command  in  8 each  TLP type
- i_cpl_flags / i_wr_flags / i_rd_flags  in  14 each  header flags
- i_cpl_address / i_wr_address / i_rd_address  in  64 each  TLP address
- i_cpl_requester_id / i_wr_requester_id / i_rd_requester_id  in  16 each
- i_cpl_tag / i_wr_tag / i_rd_tag  in  8 each
- i_cpl_dword_cnt / i_wr_dword_cnt / i_rd_dword_cnt  in  10 each  requested dwords
- o_cpl_gnt / o_wr_gnt / o_rd_gnt  out  1 each  level, high while owning engine
- o_cpl_done / o_wr_done / o_rd_done  out  1 each  one-cycle pulse
- o_egress_enable  out  1  to engine i_enable
- i_egress_finished  in  1  from engine o_finished
- o_egress_command  out  8  latched field
- o_egress_flags  out  14  latched field
- o_egress_address  out  64  latched field
- o_egress_requester_id  out  16  latched field
- o_egress_tag  out  8  latched field
- o_egress_req_dword_cnt  out  10  latched field
- o_egress_data_sel  out  2  FIFO mux select = granted id
- o_busy  out  1  state != IDLE
- o_stall  out  1  watchdog expired
- o_state  out  2  FSM state

Behaviour:
- Reset (async, rst_n=0): every output is 0, state IDLE, RR pointer = 2 so CPL is first in order.
- State encoding: IDLE=0, ISSUE=1, RELEASE=2.
- IDLE:
  - If any req is high, pick a winner. Round-robin order starts at (last_grant+1) mod 3.
  - In that same cycle, register all six of the winner's header fields onto the o_egress_* buses, set the winner's gnt and o_egress_data_sel, update last_grant, and go to ISSUE.
  - Request fields need only be valid in the cycle req is sampled high in IDLE.
- ISSUE:
  - o_egress_enable=1; header outputs held constant.
  - On i_egress_finished=1: drive enable to 0, pulse the winner's done for 1 cycle, go to RELEASE.
- RELEASE:
  - gnt is held. Wait for i_egress_finished=0, then clear gnt and go to IDLE.
  - Minimum residency is 2 cycles, because the engine holds finished one cycle after enable falls.
- Requester rule:
  - Deassert req within 1 cycle of done. A req still high when IDLE is re-entered is a new request.
  - Changes to req of the current owner during ISSUE/RELEASE are ignored.
- Latency: req high in IDLE -> enable high 1 cycle later. Finished -> enable low in the next cycle.
- Simultaneous requests: exactly one gnt at a time; o_egress_data_sel always equals the index of the single high gnt.
- Watchdog:
  - Counter clears on entering ISSUE and increments each cycle in ISSUE, saturating at all-ones.
  - o_stall=1 while saturated; it clears on leaving ISSUE. There is no abort; the engine transaction is never cut short.
- Reset mid-operation: the scheduler returns to IDLE with enable low. The engine shares rst_n-derived reset, so there is no dangling handshake.
- Finished high while in IDLE (spurious): ignored.

Optional Feature:
- Macro: PCIE_EGRESS_CPL_PRIORITY_EN.
- Defined: CPL wins whenever i_cpl_req is high in IDLE. WR/RD round-robin between themselves only; the RR pointer is not updated on CPL grants.
- Undefined: pure 3-way round-robin.

Decomposition:
- Shared package/defines header holds:
  - requester ids EGR_ID_CPL=0, EGR_ID_WR=1, EGR_ID_RD=2;
  - FSM state encodings;
  - header field widths (8/14/64/16/8/10).
- Sub-module pcie_egress_rr_arbiter contains the 3-input round-robin pick (req vector, last_grant -> one-hot winner, id) and the priority-override logic.

Test Plan:
- Single request: WR req with address 0x0000_0001_2000_0000 and cnt 4; engine model asserts finished 10 cycles after enable -> o_wr_gnt=1, enable high 1 cycle after req, o_egress_address matches, o_wr_done is a single pulse, FSM back in IDLE after RELEASE.
- Fairness: all three reqs held continuously for 6 transactions -> grant order CPL,WR,RD,CPL,WR,RD (macro undefined); with macro defined -> CPL on every grant.
- Field stability: change i_rd_tag from 0x11 to 0x22 after grant -> o_egress_tag stays 0x11 until IDLE.
- Handshake timing: engine holds finished 1 cycle after enable low -> RELEASE lasts ≥2 cycles and no new enable is issued before finished=0.
- Watchdog: engine never finishes, with WDOG_W=4 -> o_stall=1 after 15 ISSUE cycles and enable still high; finish then clears o_stall.
- Async reset mid-ISSUE: rst_n=0 -> all gnt, enable and done go to 0 immediately; after release, CPL is granted first.
